// File: rtl/note_sprite_renderer_if.sv
// Sprite renderer bus: note table write port, pixel stream in,
// sprite ROM address/data, and the rendered pixel stream out.
// master drives table writes, pixels and ROM data; slave is the renderer.
interface note_sprite_renderer_if #(
    parameter int MAX_NOTES = 8
);
    localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

    logic          note_we;
    logic [IW-1:0] note_idx;
    logic [9:0]    note_x;
    logic [9:0]    note_y;
    logic          note_en;
    logic          clear_all;
    logic          frame_start;
    logic [9:0]    hcount;
    logic [9:0]    vcount;
    logic          pix_valid_in;
    logic [9:0]    rom_addr;
    logic          rom_pixel;
    logic          pix_out;
    logic          pix_valid_out;
    logic [IW-1:0] hit_idx;

    modport master (
        output note_we, note_idx, note_x, note_y, note_en,
        output clear_all, frame_start,
        output hcount, vcount, pix_valid_in, rom_pixel,
        input  rom_addr, pix_out, pix_valid_out, hit_idx
    );

    modport slave (
        input  note_we, note_idx, note_x, note_y, note_en,
        input  clear_all, frame_start,
        input  hcount, vcount, pix_valid_in, rom_pixel,
        output rom_addr, pix_out, pix_valid_out, hit_idx
    );
endinterface

// File: rtl/note_sprite_renderer.sv
// Note sprite renderer: hit-tests each pixel against a note table, drives
// the 20x30 sprite ROM address (S1) and realigns ROM data into pix_out (S2).
// Ports: clk, reset (sync, active-high), bus (note_sprite_renderer_if.slave).
// Optional macro NOTE_SHADOW_EN: double-buffered table committed on frame_start.
module note_sprite_renderer #(
    parameter int MAX_NOTES = 8,
    parameter int SPRITE_W  = 20,
    parameter int SPRITE_H  = 30
) (
    input  logic clk,
    input  logic reset,
    note_sprite_renderer_if.slave bus
);
    localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

    // Table written by note_we/clear_all.
    logic [MAX_NOTES-1:0] wr_en_q, wr_en_d;
    logic [9:0]           wr_x_q [MAX_NOTES];
    logic [9:0]           wr_x_d [MAX_NOTES];
    logic [9:0]           wr_y_q [MAX_NOTES];
    logic [9:0]           wr_y_d [MAX_NOTES];

    // Table seen by the hit test.
    logic [MAX_NOTES-1:0] act_en;
    logic [9:0]           act_x [MAX_NOTES];
    logic [9:0]           act_y [MAX_NOTES];

    logic [MAX_NOTES-1:0] slot_hit;
    logic                 hit_d;
    logic [IW-1:0]        idx_d;
    logic [9:0]           win_x, win_y;
    logic [9:0]           dx, dy;
    logic [9:0]           rom_addr_d, rom_addr_q;
    logic                 s1_hit_q;
    logic [IW-1:0]        s1_idx_q;
    logic                 s1_valid_q;
    logic                 pix_d, pix_q;
    logic [IW-1:0]        hit_idx_d, hit_idx_q;
    logic                 pv_d, pv_q;

    // clear_all takes precedence over a simultaneous write.
    always_comb begin
        wr_en_d = wr_en_q;
        wr_x_d  = wr_x_q;
        wr_y_d  = wr_y_q;
        if (bus.clear_all) begin
            wr_en_d = '0;
        end else if (bus.note_we) begin
            wr_en_d[bus.note_idx] = bus.note_en;
            wr_x_d[bus.note_idx]  = bus.note_x;
            wr_y_d[bus.note_idx]  = bus.note_y;
        end
    end

`ifdef NOTE_SHADOW_EN
    logic [MAX_NOTES-1:0] act_en_q, act_en_d;
    logic [9:0]           act_x_q [MAX_NOTES];
    logic [9:0]           act_x_d [MAX_NOTES];
    logic [9:0]           act_y_q [MAX_NOTES];
    logic [9:0]           act_y_d [MAX_NOTES];

    // Commit takes the shadow as it stood before this cycle's write.
    always_comb begin
        act_en_d = act_en_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        if (bus.frame_start) begin
            act_en_d = wr_en_q;
            act_x_d  = wr_x_q;
            act_y_d  = wr_y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_en_q <= '0;
            act_x_q  <= '{default: '0};
            act_y_q  <= '{default: '0};
        end else begin
            act_en_q <= act_en_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
        end
    end

    assign act_en = act_en_q;
    assign act_x  = act_x_q;
    assign act_y  = act_y_q;
`else
    logic unused_frame_start;
    assign unused_frame_start = bus.frame_start;

    assign act_en = wr_en_q;
    assign act_x  = wr_x_q;
    assign act_y  = wr_y_q;
`endif

    // 11-bit bounds so boxes near column/row 1023 clip instead of wrapping.
    always_comb begin
        slot_hit = '0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            slot_hit[i] = act_en[i] & bus.pix_valid_in
                & ({1'b0, bus.hcount} >= {1'b0, act_x[i]})
                & ({1'b0, bus.hcount} < ({1'b0, act_x[i]} + 11'(SPRITE_W)))
                & ({1'b0, bus.vcount} >= {1'b0, act_y[i]})
                & ({1'b0, bus.vcount} < ({1'b0, act_y[i]} + 11'(SPRITE_H)));
        end
    end

    // Scan downward so the lowest hitting index is written last and wins.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        win_x = '0;
        win_y = '0;
        for (int i = MAX_NOTES - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit_d = 1'b1;
                idx_d = IW'(i);
                win_x = act_x[i];
                win_y = act_y[i];
            end
        end
    end

    // dy*20 as (dy<<4)+(dy<<2); range 0..599 for a hit, 0 on a miss.
    always_comb begin
        dx = bus.hcount - win_x;
        dy = bus.vcount - win_y;
        rom_addr_d = '0;
        if (hit_d) begin
            rom_addr_d = (dy << 4) + (dy << 2) + dx;
        end
    end

    // rom_pixel arrives one cycle after rom_addr, aligned with s1_hit_q.
    always_comb begin
        pix_d     = s1_hit_q & bus.rom_pixel;
        hit_idx_d = s1_idx_q;
        pv_d      = s1_valid_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q    <= '0;
            wr_x_q     <= '{default: '0};
            wr_y_q     <= '{default: '0};
            rom_addr_q <= '0;
            s1_hit_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_valid_q <= 1'b0;
            pix_q      <= 1'b0;
            hit_idx_q  <= '0;
            pv_q       <= 1'b0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            rom_addr_q <= rom_addr_d;
            s1_hit_q   <= hit_d;
            s1_idx_q   <= idx_d;
            s1_valid_q <= bus.pix_valid_in;
            pix_q      <= pix_d;
            hit_idx_q  <= hit_idx_d;
            pv_q       <= pv_d;
        end
    end

    assign bus.rom_addr      = rom_addr_q;
    assign bus.pix_out       = pix_q;
    assign bus.hit_idx       = hit_idx_q;
    assign bus.pix_valid_out = pv_q;
endmodule

// File: tb/tb_note_sprite_renderer.sv
// Testbench for note_sprite_renderer: sprite ROM model plus a note-table
// reference model; directed scenarios and randomized traffic.
module tb_note_sprite_renderer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    note_sprite_renderer_if #(.MAX_NOTES(8)) ifc ();

    note_sprite_renderer #(
        .MAX_NOTES(8),
        .SPRITE_W(20),
        .SPRITE_H(30)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(ifc.slave)
    );

    bit rom [1024];
    assign ifc.rom_pixel = rom[ifc.rom_addr];

    int n_chk = 0;
    int n_fail = 0;

    // Reference tables: m_* is what the hit test sees, s_* the shadow.
    int m_en [8], m_x [8], m_y [8];
    int s_en [8], s_x [8], s_y [8];
    // Previous pixel's result (waiting on the ROM) and current expectations.
    int ph, pi, pa, pv;
    int exp_addr, exp_pix, exp_idx, exp_pv;
    int map [600];

    function automatic void model_hit(input int h, input int v, input bit val,
                                      output bit hit, output int idx,
                                      output int addr);
        hit = 0;
        idx = 0;
        addr = 0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && m_en[i] != 0 && val
                && h >= m_x[i] && h < m_x[i] + 20
                && v >= m_y[i] && v < m_y[i] + 30) begin
                hit = 1;
                idx = i;
                addr = (v - m_y[i]) * 20 + (h - m_x[i]);
            end
        end
    endfunction

    function automatic void model_update();
        int k;
        k = int'(ifc.note_idx);
`ifdef NOTE_SHADOW_EN
        if (ifc.frame_start) begin
            m_en = s_en;
            m_x = s_x;
            m_y = s_y;
        end
        if (ifc.clear_all) begin
            for (int i = 0; i < 8; i++) s_en[i] = 0;
        end else if (ifc.note_we) begin
            s_en[k] = int'(ifc.note_en);
            s_x[k] = int'(ifc.note_x);
            s_y[k] = int'(ifc.note_y);
        end
`else
        if (ifc.clear_all) begin
            for (int i = 0; i < 8; i++) m_en[i] = 0;
        end else if (ifc.note_we) begin
            m_en[k] = int'(ifc.note_en);
            m_x[k] = int'(ifc.note_x);
            m_y[k] = int'(ifc.note_y);
        end
`endif
    endfunction

    task automatic step(input int h, input int v, input bit val);
        bit eh;
        int ei, ea;
        ifc.hcount = 10'(h);
        ifc.vcount = 10'(v);
        ifc.pix_valid_in = val;
        model_hit(h, v, val, eh, ei, ea);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_addr = 0; exp_pix = 0; exp_idx = 0; exp_pv = 0;
            ph = 0; pi = 0; pa = 0; pv = 0;
            for (int i = 0; i < 8; i++) begin
                m_en[i] = 0; m_x[i] = 0; m_y[i] = 0;
                s_en[i] = 0; s_x[i] = 0; s_y[i] = 0;
            end
        end else begin
            exp_addr = ea;
            exp_pix = (ph != 0) ? int'(rom[pa]) : 0;
            exp_idx = pi;
            exp_pv = pv;
            ph = int'(eh); pi = ei; pa = ea; pv = int'(val);
            model_update();
        end
        ifc.note_we = 1'b0;
        ifc.clear_all = 1'b0;
        ifc.frame_start = 1'b0;
    endtask

    task automatic wr(input int idx, input int en, input int x, input int y);
        ifc.note_we = 1'b1;
        ifc.note_idx = 3'(idx);
        ifc.note_en = 1'(en);
        ifc.note_x = 10'(x);
        ifc.note_y = 10'(y);
        step(0, 0, 0);
    endtask

    task automatic clr();
        ifc.clear_all = 1'b1;
        step(0, 0, 0);
    endtask

    // frame_start makes shadow writes visible; ignored in the default build.
    task automatic commit();
        ifc.frame_start = 1'b1;
        step(0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, 0, 0);
        step(5, 5, 1);
        n_chk++;
        if (ifc.rom_addr !== 10'd0) begin
            n_fail++; $display("FAIL reset_addr got %0d want 0", ifc.rom_addr);
        end
        n_chk++;
        if (ifc.pix_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_pix got %b want 0", ifc.pix_out);
        end
        n_chk++;
        if (ifc.pix_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_pv got %b want 0", ifc.pix_valid_out);
        end
        n_chk++;
        if (ifc.hit_idx !== 3'd0) begin
            n_fail++; $display("FAIL reset_idx got %0d want 0", ifc.hit_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_empty_sweep();
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 800; h++) begin
                step(h, v, h < 640);
                n_chk++;
                if (ifc.rom_addr !== 10'd0) begin
                    n_fail++;
                    $display("FAIL empty_addr got %0d want 0", ifc.rom_addr);
                end
                n_chk++;
                if (ifc.pix_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL empty_pix got %b want 0", ifc.pix_out);
                end
                n_chk++;
                if (ifc.pix_valid_out !== 1'(exp_pv)) begin
                    n_fail++;
                    $display("FAIL empty_pv got %b want %0d",
                             ifc.pix_valid_out, exp_pv);
                end
            end
        end
    endtask

    task automatic test_corners();
        int ph_ [6] = '{100, 119, 100, 119, 120, 100};
        int pv_ [6] = '{50, 50, 79, 79, 50, 80};
        int wa [6] = '{0, 19, 580, 599, 0, 0};
        int wp [6] = '{1, 1, 1, 1, 0, 0};
        clr();
        wr(0, 1, 100, 50);
        commit();
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                step(ph_[k], pv_[k], 1);
                n_chk++;
                if (ifc.rom_addr !== 10'(wa[k])) begin
                    n_fail++;
                    $display("FAIL corner_addr[%0d] got %0d want %0d",
                             k, ifc.rom_addr, wa[k]);
                end
            end else begin
                step(0, 0, 0);
            end
            if (k >= 1) begin
                n_chk++;
                if (ifc.pix_out !== 1'(wp[k-1])) begin
                    n_fail++;
                    $display("FAIL corner_pix[%0d] got %b want %0d",
                             k - 1, ifc.pix_out, wp[k-1]);
                end
            end
        end
    endtask

    task automatic test_oval();
        for (int n = 0; n < 601; n++) begin
            if (n < 600) step(100 + n % 20, 50 + n / 20, 1);
            else step(0, 0, 0);
            n_chk++;
            if (ifc.rom_addr !== 10'(exp_addr)) begin
                n_fail++;
                $display("FAIL oval_addr got %0d want %0d",
                         ifc.rom_addr, exp_addr);
            end
            n_chk++;
            if (ifc.pix_out !== 1'(exp_pix)) begin
                n_fail++;
                $display("FAIL oval_pix got %b want %0d", ifc.pix_out, exp_pix);
            end
            if (n >= 1) map[n-1] = int'(ifc.pix_out);
        end
        for (int c = 5; c < 15; c++) begin
            n_chk++;
            if (map[13*20+c] !== 1) begin
                n_fail++;
                $display("FAIL oval_r13c%0d got %0d want 1", c, map[13*20+c]);
            end
        end
        n_chk++;
        if (map[16*20+2] !== 1) begin
            n_fail++; $display("FAIL oval_r16c2 got %0d want 1", map[16*20+2]);
        end
        n_chk++;
        if (map[16*20+17] !== 1) begin
            n_fail++; $display("FAIL oval_r16c17 got %0d want 1", map[16*20+17]);
        end
        n_chk++;
        if (map[16*20+9] !== 0) begin
            n_fail++; $display("FAIL oval_r16c9 got %0d want 0", map[16*20+9]);
        end
    endtask

    task automatic test_priority();
        clr();
        wr(1, 1, 200, 100);
        wr(3, 1, 200, 100);
        commit();
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 10; n++) begin
                step(200 + $urandom_range(0, 19), 100 + $urandom_range(0, 29), 1);
                step(0, 0, 0);
                n_chk++;
                if (ifc.hit_idx !== ((pass == 0) ? 3'd1 : 3'd3)) begin
                    n_fail++;
                    $display("FAIL prio_idx got %0d want %0d",
                             ifc.hit_idx, (pass == 0) ? 1 : 3);
                end
            end
            wr(1, 0, 200, 100);
            commit();
        end
    endtask

    task automatic test_edge();
        int h;
        bit in;
        clr();
        wr(5, 1, 1015, 10);
        commit();
        for (int n = 0; n < 20; n++) begin
            h = (n < 9) ? 1015 + n : n - 9;
            in = (h >= 1015);
            step(h, 12, 1);
            n_chk++;
            if (ifc.rom_addr !== (in ? 10'(40 + h - 1015) : 10'd0)) begin
                n_fail++;
                $display("FAIL edge_addr h=%0d got %0d", h, ifc.rom_addr);
            end
            step(0, 0, 0);
            n_chk++;
            if (ifc.hit_idx !== (in ? 3'd5 : 3'd0)) begin
                n_fail++;
                $display("FAIL edge_idx h=%0d got %0d want %0d",
                         h, ifc.hit_idx, in ? 5 : 0);
            end
        end
    endtask

    task automatic test_clear_we();
        clr();
        wr(4, 1, 300, 300);
        ifc.clear_all = 1'b1;
        wr(2, 1, 300, 300);
        commit();
        for (int n = 0; n < 5; n++) begin
            step(300 + $urandom_range(0, 19), 300 + $urandom_range(0, 29), 1);
            n_chk++;
            if (ifc.rom_addr !== 10'd0) begin
                n_fail++;
                $display("FAIL clrwe_addr got %0d want 0", ifc.rom_addr);
            end
            step(0, 0, 0);
            n_chk++;
            if (ifc.pix_out !== 1'b0 || ifc.hit_idx !== 3'd0) begin
                n_fail++;
                $display("FAIL clrwe_hit got pix=%b idx=%0d want 0/0",
                         ifc.pix_out, ifc.hit_idx);
            end
        end
    endtask

    task automatic test_shadow();
        int want;
        clr();
        commit();
        wr(6, 1, 400, 200);
        step(405, 205, 1);
        step(0, 0, 0);
`ifdef NOTE_SHADOW_EN
        want = 0;
`else
        want = 6;
`endif
        n_chk++;
        if (ifc.hit_idx !== 3'(want)) begin
            n_fail++;
            $display("FAIL shadow_pre got %0d want %0d", ifc.hit_idx, want);
        end
        ifc.frame_start = 1'b1;
        wr(7, 1, 500, 300);
        step(405, 205, 1);
        step(505, 305, 1);
        n_chk++;
        if (ifc.hit_idx !== 3'd6) begin
            n_fail++; $display("FAIL shadow_commit got %0d want 6", ifc.hit_idx);
        end
        step(0, 0, 0);
`ifdef NOTE_SHADOW_EN
        want = 0;
`else
        want = 7;
`endif
        n_chk++;
        if (ifc.hit_idx !== 3'(want)) begin
            n_fail++;
            $display("FAIL shadow_same got %0d want %0d", ifc.hit_idx, want);
        end
        commit();
        step(505, 305, 1);
        step(0, 0, 0);
        n_chk++;
        if (ifc.hit_idx !== 3'd7) begin
            n_fail++; $display("FAIL shadow_next got %0d want 7", ifc.hit_idx);
        end
    endtask

    task automatic test_random();
        int j, h, v, r;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                ifc.note_we = 1'b1;
                ifc.note_idx = 3'($urandom_range(0, 7));
                ifc.note_en = 1'($urandom_range(0, 3) != 0);
                ifc.note_x = 10'($urandom_range(0, 1023));
                ifc.note_y = 10'($urandom_range(0, 1023));
            end
            if (r >= 12 && r < 14) ifc.clear_all = 1'b1;
            if (r >= 90) ifc.frame_start = 1'b1;
            j = $urandom_range(0, 7);
            h = (m_x[j] + $urandom_range(0, 24) - 2) & 1023;
            v = (m_y[j] + $urandom_range(0, 34) - 2) & 1023;
            step(h, v, $urandom_range(0, 7) != 0);
            n_chk++;
            if (ifc.rom_addr !== 10'(exp_addr)) begin
                n_fail++;
                $display("FAIL rnd_addr got %0d want %0d", ifc.rom_addr, exp_addr);
            end
            n_chk++;
            if (ifc.pix_out !== 1'(exp_pix)) begin
                n_fail++;
                $display("FAIL rnd_pix got %b want %0d", ifc.pix_out, exp_pix);
            end
            n_chk++;
            if (ifc.hit_idx !== 3'(exp_idx)) begin
                n_fail++;
                $display("FAIL rnd_idx got %0d want %0d", ifc.hit_idx, exp_idx);
            end
            n_chk++;
            if (ifc.pix_valid_out !== 1'(exp_pv)) begin
                n_fail++;
                $display("FAIL rnd_pv got %b want %0d", ifc.pix_valid_out, exp_pv);
            end
        end
    endtask

    task automatic test_midline_reset();
        clr();
        wr(2, 1, 100, 50);
        commit();
        step(105, 55, 1);
        step(106, 55, 1);
        reset = 1'b1;
        step(107, 55, 1);
        reset = 1'b0;
        n_chk++;
        if (ifc.rom_addr !== 10'd0 || ifc.pix_out !== 1'b0 ||
            ifc.pix_valid_out !== 1'b0 || ifc.hit_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_out got addr=%0d pix=%b pv=%b idx=%0d want 0",
                     ifc.rom_addr, ifc.pix_out, ifc.pix_valid_out, ifc.hit_idx);
        end
        step(105, 55, 1);
        n_chk++;
        if (ifc.rom_addr !== 10'd0 || ifc.pix_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flush got addr=%0d pv=%b want 0/0",
                     ifc.rom_addr, ifc.pix_valid_out);
        end
        step(0, 0, 0);
        n_chk++;
        if (ifc.pix_valid_out !== 1'b1 || ifc.hit_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_after got pv=%b idx=%0d want 1/0",
                     ifc.pix_valid_out, ifc.hit_idx);
        end
    endtask

    initial begin
        ifc.note_we = 1'b0;
        ifc.note_idx = '0;
        ifc.note_x = '0;
        ifc.note_y = '0;
        ifc.note_en = 1'b0;
        ifc.clear_all = 1'b0;
        ifc.frame_start = 1'b0;
        ifc.hcount = '0;
        ifc.vcount = '0;
        ifc.pix_valid_in = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 1'($urandom_range(0, 1));
        rom[0] = 1; rom[19] = 1; rom[580] = 1; rom[599] = 1;
        for (int c = 5; c < 15; c++) rom[13*20+c] = 1;
        rom[16*20+2] = 1; rom[16*20+17] = 1; rom[16*20+9] = 0;

        test_reset();
        test_empty_sweep();
        test_corners();
        test_oval();
        test_priority();
        test_edge();
        test_clear_we();
        test_shadow();
        test_random();
        test_midline_reset();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
